// File: rtl/sdram_arb_pkg.sv
// Shared widths and types for the SDRAM port arbiter.
package sdram_arb_pkg;
  localparam int SDRAM_AW     = 26;
  localparam int SDRAM_DW     = 32;
  localparam int SDRAM_SW     = 4;
  localparam int BURST_LEN    = 16;
  localparam int NREQ_DEFAULT = 2;

  typedef logic [$clog2(NREQ_DEFAULT)-1:0] src_id_t;
endpackage

// File: rtl/sdram_arb_srcfifo.sv
// Source-ID FIFO: remembers which requester owns each outstanding read, oldest at head.
module sdram_arb_srcfifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port; write bursts lock the grant,
// read returns are routed back in order through the source-ID FIFO.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic [NREQ-1:0]          req_request_i,
  input  logic [NREQ*SDRAM_AW-1:0] req_addr_i,
  input  logic [NREQ-1:0]          req_write_i,
  input  logic [NREQ-1:0]          req_burst_i,
  input  logic [NREQ*SDRAM_SW-1:0] req_wstrb_i,
  input  logic [NREQ*SDRAM_DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [NREQ-1:0]          req_rvalid_o,
  output logic [NREQ-1:0]          req_complete_o,
  output logic [SDRAM_DW-1:0]      req_rdata_o,
  output logic [SDRAM_AW-1:0]      req_raddress_o,
  input  logic                     sdram_ready_i,
  output logic                     sdram_request_o,
  output logic [SDRAM_AW-1:0]      sdram_addr_o,
  output logic                     sdram_write_o,
  output logic                     sdram_burst_o,
  output logic [SDRAM_SW-1:0]      sdram_wstrb_o,
  output logic [SDRAM_DW-1:0]      sdram_wdata_o,
  input  logic                     sdram_rvalid_i,
  input  logic [SDRAM_DW-1:0]      sdram_rdata_i,
  input  logic [SDRAM_AW-1:0]      sdram_raddress_i,
  input  logic                     sdram_complete_i,
  output logic                     arb_error_o
);
  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(BURST_LEN) + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, grant, cand, head;
  logic           lock_q, lock_d, arb_error_q, arb_error_d, found;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           fifo_full, fifo_empty, blk, accept;

  // Scan starts just past the last winner so each requester gets a turn.
  always_comb begin
    grant = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_request_i[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_id_q;
  end

  always_comb begin
    sdram_addr_o  = '0;
    sdram_write_o = 1'b0;
    sdram_burst_o = 1'b0;
    sdram_wstrb_o = '0;
    sdram_wdata_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sdram_addr_o  = req_addr_i[i*SDRAM_AW +: SDRAM_AW];
        sdram_write_o = req_write_i[i];
        sdram_burst_o = req_burst_i[i];
        sdram_wstrb_o = req_wstrb_i[i*SDRAM_SW +: SDRAM_SW];
        sdram_wdata_o = req_wdata_i[i*SDRAM_DW +: SDRAM_DW];
      end
    end
  end

  // A full FIFO only stalls reads; full is taken before any same-cycle pop.
  assign blk             = fifo_full & ~req_write_i[grant];
  assign sdram_request_o = reset_ni & req_request_i[grant] & ~blk;
  assign accept          = sdram_request_o & sdram_ready_i;

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = reset_ni & sdram_ready_i & ~blk;
    for (int i = 0; i < NREQ; i++) begin
      req_rvalid_o[i]   = reset_ni & sdram_rvalid_i & ~fifo_empty & (head == IDW'(i));
      req_complete_o[i] = req_rvalid_o[i] & sdram_complete_i;
    end
  end

  assign req_rdata_o    = sdram_rdata_i;
  assign req_raddress_o = sdram_raddress_i;
  assign arb_error_o    = arb_error_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    beat_cnt_d  = beat_cnt_q;
    arb_error_d = arb_error_q | (sdram_rvalid_i & fifo_empty);
    if (accept) begin
      rr_ptr_d = grant;
      if (lock_q) begin
        if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
          lock_d     = 1'b0;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end else if (sdram_write_o && sdram_burst_o) begin
        lock_d     = 1'b1;
        lock_id_d  = grant;
        beat_cnt_d = BW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr_q    <= IDW'(NREQ - 1);
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      beat_cnt_q  <= '0;
      arb_error_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      beat_cnt_q  <= beat_cnt_d;
      arb_error_q <= arb_error_d;
    end
  end

  sdram_arb_srcfifo #(.DEPTH(FIFO_DEPTH), .W(IDW)) u_srcfifo (
    .clk_i  (clock_i),
    .rst_ni (reset_ni),
    .push_i (accept & ~sdram_write_o),
    .din_i  (grant),
    .pop_i  (sdram_rvalid_i & sdram_complete_i),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (NREQ=2, FIFO_DEPTH=4): vector table plus burst/return/reset sequences.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam logic [25:0] A0 = 26'h0000111;
  localparam logic [25:0] A1 = 26'h0000222;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = '0, wr = '0, bu = '0;
  logic        srdy = 1'b0, rv = 1'b0, cmp = 1'b0;
  logic [31:0] rdata = '0;
  logic [25:0] raddr = '0;

  logic [1:0]  ready, rvalid, complete;
  logic [31:0] o_rdata, s_wdata;
  logic [25:0] o_raddr, s_addr;
  logic        s_req, s_write, s_burst, err;
  logic [3:0]  s_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.NREQ(2), .FIFO_DEPTH(4)) dut (
    .clock_i         (clk),
    .reset_ni        (rst_n),
    .req_request_i   (req),
    .req_addr_i      ({A1, A0}),
    .req_write_i     (wr),
    .req_burst_i     (bu),
    .req_wstrb_i     ({4'h3, 4'hC}),
    .req_wdata_i     ({D1, D0}),
    .req_ready_o     (ready),
    .req_rvalid_o    (rvalid),
    .req_complete_o  (complete),
    .req_rdata_o     (o_rdata),
    .req_raddress_o  (o_raddr),
    .sdram_ready_i   (srdy),
    .sdram_request_o (s_req),
    .sdram_addr_o    (s_addr),
    .sdram_write_o   (s_write),
    .sdram_burst_o   (s_burst),
    .sdram_wstrb_o   (s_wstrb),
    .sdram_wdata_o   (s_wdata),
    .sdram_rvalid_i  (rv),
    .sdram_rdata_i   (rdata),
    .sdram_raddress_i(raddr),
    .sdram_complete_i(cmp),
    .arb_error_o     (err)
  );

  typedef struct {
    logic [1:0]  req, wr, bu;
    logic        srdy, rv, cmp;
    logic [1:0]  e_ready;
    logic        e_sreq;
    logic [25:0] e_addr;
    logic [1:0]  e_rv, e_cmp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] b,
                       input logic sr, input logic v, input logic c);
    req = r; wr = w; bu = b; srdy = sr; rv = v; cmp = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // round-robin reads fill the 4-deep FIFO, then full/write-bypass/pop/drain
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, A0, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b10, 1, A1, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, A0, 2'b00, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b10, 1, A1, 2'b00, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0, A0, 2'b00, 2'b00};
    tbl[5]  = '{2'b01, 2'b01, 2'b00, 1, 0, 0, 2'b01, 1, A0, 2'b00, 2'b00};
    tbl[6]  = '{2'b10, 2'b10, 2'b00, 1, 0, 0, 2'b10, 1, A1, 2'b00, 2'b00};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 1, 1, 1, 2'b00, 0, A0, 2'b01, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, A0, 2'b00, 2'b00};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, A0, 2'b10, 2'b10};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, A0, 2'b01, 2'b01};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, A0, 2'b10, 2'b10};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, A0, 2'b01, 2'b01};
    tbl[13] = '{2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, A1, 2'b00, 2'b00};

    // reset: outputs held inactive even with live inputs
    #1 rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 1, 1, 1);
    @(negedge clk);
    chk("rst sreq", 32'(s_req), 32'd0);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].req, tbl[i].wr, tbl[i].bu, tbl[i].srdy, tbl[i].rv, tbl[i].cmp);
      rdata = 32'hDEAD_0000 + 32'(i);
      raddr = 26'h100 + 26'(i);
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 32'(ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d sreq", i), 32'(s_req), 32'(tbl[i].e_sreq));
      if (tbl[i].e_sreq) chk($sformatf("v%0d addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d complete", i), 32'(complete), 32'(tbl[i].e_cmp));
      if (tbl[i].rv) begin
        chk($sformatf("v%0d rdata", i), o_rdata, 32'hDEAD_0000 + 32'(i));
        chk($sformatf("v%0d raddr", i), 32'(o_raddr), 32'(26'h100 + 26'(i)));
      end
      next_cycle();
    end

    // single read req1, burst read req0, then 1 + 16 returned beats
    drive(2'b10, 2'b00, 2'b00, 1, 0, 0);
    @(negedge clk);
    chk("rd1 ready", 32'(ready), 32'b10);
    next_cycle();
    drive(2'b01, 2'b00, 2'b01, 1, 0, 0);
    @(negedge clk);
    chk("rd0 ready", 32'(ready), 32'b01);
    chk("rd0 burst", 32'(s_burst), 32'd1);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 0, 1, 1);
    @(negedge clk);
    chk("ret1 rvalid", 32'(rvalid), 32'b10);
    chk("ret1 complete", 32'(complete), 32'b10);
    next_cycle();
    for (int b = 1; b <= 16; b++) begin
      drive(2'b00, 2'b00, 2'b00, 0, 1, (b == 16));
      @(negedge clk);
      chk($sformatf("ret0 b%0d rvalid", b), 32'(rvalid), 32'b01);
      chk($sformatf("ret0 b%0d complete", b), 32'(complete), (b == 16) ? 32'b01 : 32'b00);
      next_cycle();
    end

    // req1 write burst locks out req0; a mid-burst gap keeps the lock
    for (int b = 1; b <= 17; b++) begin
      if (b == 9) begin
        drive(2'b01, 2'b11, 2'b10, 1, 0, 0);
        @(negedge clk);
        chk("gap sreq", 32'(s_req), 32'd0);
        chk("gap ready", 32'(ready), 32'b10);
      end else begin
        drive(2'b11, 2'b11, 2'b10, 1, 0, 0);
        @(negedge clk);
        chk($sformatf("wb b%0d ready", b), 32'(ready), 32'b10);
        chk($sformatf("wb b%0d wdata", b), s_wdata, D1);
        chk($sformatf("wb b%0d wstrb", b), 32'(s_wstrb), 32'h3);
      end
      next_cycle();
    end
    drive(2'b11, 2'b11, 2'b10, 1, 0, 0);
    @(negedge clk);
    chk("post burst ready", 32'(ready), 32'b01);
    chk("post burst wdata", s_wdata, D0);
    next_cycle();

    // stray read beat sets a sticky error
    drive(2'b00, 2'b00, 2'b00, 0, 1, 0);
    @(negedge clk);
    chk("stray rvalid", 32'(rvalid), 32'b00);
    chk("stray err pre", 32'(err), 32'd0);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("err sticky %0d", c), 32'(err), 32'd1);
      next_cycle();
    end

    // reset in the middle of a locked burst with a read outstanding
    drive(2'b01, 2'b00, 2'b00, 1, 0, 0);
    @(negedge clk);
    chk("pre-rst read ready", 32'(ready), 32'b01);
    next_cycle();
    for (int b = 1; b <= 6; b++) begin
      drive(2'b11, 2'b11, 2'b10, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("rb b%0d ready", b), 32'(ready), 32'b10);
      next_cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst sreq", 32'(s_req), 32'd0);
    chk("midrst ready", 32'(ready), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("after rst ready", 32'(ready), 32'b01);
    chk("after rst addr", 32'(s_addr), 32'(A0));
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 0, 1, 1);
    @(negedge clk);
    chk("fifo cleared rvalid", 32'(rvalid), 32'b00);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk);
    chk("fifo cleared err", 32'(err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
